// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select lines of a 4:1
// single-bit mux on behalf of four requesters. Ownership lasts for a burst
// and is capped at MAX_HOLD consecutive cycles when others are waiting.
// Optional build macro MUX4_ARB_LOCK_EN adds a 'lock' input that lets the
// current owner ignore the hold limit until its request drops.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       last_owner, last_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_on;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // Returns {found, index} of the first set candidate, searching from last+1
  // and wrapping modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] probe;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      probe = last + 2'(k);
      if (!found && cand[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
    return {found, idx};
  endfunction

  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic       owner_req;
  logic       at_limit;
  logic       do_take;
  logic [1:0] take_idx;

  // Next-state and registered-output decision for IDLE/GRANT.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    cnt_nxt   = hold_cnt;
    last_nxt  = last_owner;
    do_take   = 1'b0;
    take_idx  = '0;

    pick_all  = rr_pick(req, last_owner);
    pick_oth  = rr_pick(req & ~gnt, last_owner);
    owner_req = req[sel];
    at_limit  = (hold_cnt == LIMIT);

    unique case (state)
      IDLE: begin
        if (pick_all[2]) begin
          do_take  = 1'b1;
          take_idx = pick_all[1:0];
        end
      end
      GRANT: begin
        if (owner_req && (!at_limit || lock_on)) begin
          // Locked owner saturates at the limit instead of wrapping.
          if (!at_limit) cnt_nxt = hold_cnt + 1'b1;
        end else if (owner_req) begin
          // Hold expired: hand over to someone else, or restart the burst.
          if (pick_oth[2]) begin
            do_take  = 1'b1;
            take_idx = pick_oth[1:0];
          end else begin
            cnt_nxt = '0;
          end
        end else if (pick_all[2]) begin
          do_take  = 1'b1;
          take_idx = pick_all[1:0];
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_take) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << take_idx;
      sel_nxt   = take_idx;
      busy_nxt  = 1'b1;
      cnt_nxt   = '0;
      last_nxt  = take_idx;
    end
  end

  // State and output registers; last_owner resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      sel        <= sel_nxt;
      busy       <= busy_nxt;
      hold_cnt   <= cnt_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter. A stimulus
// process drives req (and lock when MUX4_ARB_LOCK_EN is defined), advances a
// behavioural model and queues the expected registered outputs; a monitor
// pops and compares them on every falling edge.
module tb_mux4_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic             lock_v;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef MUX4_ARB_LOCK_EN
    .lock     (lock_v),
`endif
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: owner index (-1 = nobody), cycles held minus one,
  // last owner and the select value presented to the mux.
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 3;
    m_sel   = 0;
  endtask

  task automatic rr_search(input logic [3:0] c, input int last,
                           output int w, output bit found);
    found = 0;
    w     = 0;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (!found && c[i]) begin
        found = 1;
        w     = i;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] r, input bit lk);
    int         w;
    bit         found;
    logic [3:0] c;
    bit         locked;
`ifdef MUX4_ARB_LOCK_EN
    locked = lk;
`else
    locked = 0;
`endif
    if (m_owner < 0) begin
      rr_search(r, m_last, w, found);
      if (found) begin
        m_owner = w; m_cnt = 0; m_last = w; m_sel = w;
      end
    end else if (r[m_owner] && (m_cnt < int'(MAX_HOLD) - 1 || locked)) begin
      if (m_cnt < int'(MAX_HOLD) - 1) m_cnt++;
    end else begin
      c = r;
      if (r[m_owner]) c[m_owner] = 1'b0;
      rr_search(c, m_last, w, found);
      if (found) begin
        m_owner = w; m_cnt = 0; m_last = w; m_sel = w;
      end else if (r[m_owner]) begin
        m_cnt = 0;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  // One clock of stimulus: drive after the monitor has sampled, queue the
  // outputs expected after the coming rising edge.
  task automatic cycle(input logic [3:0] r, input bit lk);
    exp_t e;
    @(negedge clk);
    #1;
    req    = r;
    lock_v = lk;
    model_step(r, lk);
    e.gnt  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.cnt  = CNT_W'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gnt"},  int'(gnt),      0);
    check({tag, "_sel"},  int'(sel),      0);
    check({tag, "_busy"}, int'(busy),     0);
    check({tag, "_cnt"},  int'(hold_cnt), 0);
  endtask

  // Asynchronous reset applied between edges, outputs checked before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check_reset_state(tag);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the DUT.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("gnt",      int'(gnt),      int'(e.gnt));
      check("sel",      int'(sel),      int'(e.sel));
      check("busy",     int'(busy),     int'(e.busy));
      check("hold_cnt", int'(hold_cnt), int'(e.cnt));
    end
  end

  initial begin
    logic [3:0] r;
    bit         lk;
    rst_n  = 1'b0;
    req    = 4'b0000;
    lock_v = 1'b0;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Two requesters; 0 wins first, then 2 after 0 drops.
    repeat (3) cycle(4'b0101, 0);
    repeat (2) cycle(4'b0100, 0);
    repeat (2) cycle(4'b0000, 0);

    // Full contention: each owner holds MAX_HOLD cycles, no bubble.
    repeat (20) cycle(4'b1111, 0);
    repeat (2) cycle(4'b0000, 0);

    // Single requester: continuous grant, hold_cnt wraps.
    repeat (20) cycle(4'b0010, 0);

    // Mid-grant reset, then requester 0 has top priority.
    repeat (3) cycle(4'b1000, 0);
    do_reset("mid");
    repeat (3) cycle(4'b1001, 0);
    repeat (2) cycle(4'b0000, 0);

    // Owner 2 drops as 3 rises with 0 also waiting; then idle keeps sel.
    repeat (2) cycle(4'b0100, 0);
    cycle(4'b1001, 0);
    cycle(4'b1000, 0);
    repeat (3) cycle(4'b0000, 0);

    // Lock holds ownership past the limit (no effect without the feature).
    repeat (8) cycle(4'b0011, 1);
    repeat (3) cycle(4'b0011, 0);
    repeat (2) cycle(4'b0000, 0);

    // Randomized traffic with occasional resets.
    r  = 4'b0000;
    lk = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lk = 1'($urandom_range(0, 1));
      if (n % 150 == 149) do_reset("rnd");
      cycle(r, lk);
    end
    repeat (2) cycle(4'b0000, 0);

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
